rr_fifo_wr_arb: RTL and testbench

RR_FIFO_WR_ARB -- requirements
Module: rr_fifo_wr_arb

---
 rtl/rr_fifo_wr_arb_if.sv | 26 ++
 rtl/rr_fifo_wr_arb.sv | 122 ++++++++++++
 tb/tb_rr_fifo_wr_arb.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rr_fifo_wr_arb_if.sv
// Requester/FIFO write-port bundle for rr_fifo_wr_arb.
// master: the arbiter side; slave: the requesters plus FIFO environment.
interface rr_fifo_wr_arb_if #(
   parameter int NREQ  = 4,
   parameter int DW_M1 = 8,
   parameter int IW_M1 = 1
);
   logic [NREQ-1:0]           req_rdy;
   logic [NREQ-1:0]           req_ack;
   logic [NREQ*(DW_M1+1)-1:0] req_data;
   logic                      f_rdy;
   logic                      f_ack;
   logic [DW_M1:0]            f_data;
   logic                      grant_vld;
   logic [IW_M1:0]            grant_id;

   modport master (
      input  req_rdy, req_data, f_ack,
      output req_ack, f_rdy, f_data, grant_vld, grant_id
   );

   modport slave (
      output req_rdy, req_data, f_ack,
      input  req_ack, f_rdy, f_data, grant_vld, grant_id
   );
endinterface

// File: rtl/rr_fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// Define RR_ARB_BURST_EN to let a grant carry up to BURST_M1+1 beats (default: one beat).
module rr_fifo_wr_arb #(
   parameter int NREQ     = 4,
   parameter int DW_M1    = 8,
   parameter int IW_M1    = 1,
   parameter int BURST_M1 = 3
) (
   input logic              clk,
   input logic              rst_n,
   rr_fifo_wr_arb_if.master bus
);
   localparam int DW = DW_M1 + 1;
   localparam int IW = IW_M1 + 1;

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e         r_state;
   state_e         w_state_nxt;
   logic [IW_M1:0] r_grant_id;
   logic [IW_M1:0] w_grant_id_nxt;
   logic [IW_M1:0] r_last_id;
   logic [IW_M1:0] w_last_id_nxt;

   logic           w_sel_vld;
   logic [IW_M1:0] w_sel_id;
   int             w_idx;

   logic           w_own_rdy;
   logic           w_beat;
   logic           w_burst_last;

   logic [NREQ-1:0] w_req_ack;
   logic            w_f_rdy;
   logic [DW_M1:0]  w_f_data;

   // Walk downward so the candidate closest to last_id+1 is the final one assigned.
   always_comb begin
      w_sel_vld = 1'b0;
      w_sel_id  = '0;
      w_idx     = 0;
      for (int i = NREQ; i >= 1; i--) begin
         w_idx = (int'(r_last_id) + i) % NREQ;
         if (bus.req_rdy[w_idx]) begin
            w_sel_vld = 1'b1;
            w_sel_id  = IW'(w_idx);
         end
      end
   end

   assign w_own_rdy = bus.req_rdy[r_grant_id];

`ifdef RR_ARB_BURST_EN
   localparam int CW = (BURST_M1 > 0) ? $clog2(BURST_M1 + 1) : 1;

   logic [CW-1:0] r_beat_cnt;

   // Idle clears the count, so every grant starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat_cnt <= '0;
      end else if (r_state == StIdle) begin
         r_beat_cnt <= '0;
      end else if (w_beat) begin
         r_beat_cnt <= r_beat_cnt + 1'b1;
      end
   end

   assign w_burst_last = (r_beat_cnt == CW'(BURST_M1));
`else
   assign w_burst_last = 1'b1;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_id_nxt = r_grant_id;
      w_last_id_nxt  = r_last_id;
      w_beat         = 1'b0;
      w_f_rdy        = 1'b0;
      w_f_data       = '0;
      w_req_ack      = '0;
      unique case (r_state)
         StIdle: begin
            if (w_sel_vld) begin
               w_state_nxt    = StGrant;
               w_grant_id_nxt = w_sel_id;
            end
         end
         StGrant: begin
            w_f_rdy               = w_own_rdy;
            w_f_data              = bus.req_data[r_grant_id*DW +: DW];
            w_req_ack[r_grant_id] = bus.f_ack & w_own_rdy;
            w_beat                = bus.f_ack & w_own_rdy;
            if (!w_own_rdy || (w_beat && w_burst_last)) begin
               w_state_nxt   = StIdle;
               w_last_id_nxt = r_grant_id;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_grant_id <= '0;
         r_last_id  <= IW'(NREQ - 1);
      end else begin
         r_state    <= w_state_nxt;
         r_grant_id <= w_grant_id_nxt;
         r_last_id  <= w_last_id_nxt;
      end
   end

   assign bus.req_ack   = w_req_ack;
   assign bus.f_rdy     = w_f_rdy;
   assign bus.f_data    = w_f_data;
   assign bus.grant_vld = (r_state == StGrant);
   assign bus.grant_id  = r_grant_id;
endmodule

// File: tb/tb_rr_fifo_wr_arb.sv
// Directed bench for rr_fifo_wr_arb; burst scenarios run when RR_ARB_BURST_EN is defined.
module tb_rr_fifo_wr_arb;
   localparam int NREQ     = 4;
   localparam int DW_M1    = 8;
   localparam int IW_M1    = 1;
   localparam int BURST_M1 = 3;
   localparam int DW       = DW_M1 + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   rr_fifo_wr_arb_if #(.NREQ(NREQ), .DW_M1(DW_M1), .IW_M1(IW_M1)) bus ();

   rr_fifo_wr_arb #(
      .NREQ     (NREQ),
      .DW_M1    (DW_M1),
      .IW_M1    (IW_M1),
      .BURST_M1 (BURST_M1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0] rdy;
      logic       fack;
      logic       vld;
      logic [1:0] gid;
      logic       frdy;
      logic [3:0] ack;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(logic [3:0] rdy, logic fack, logic vld, logic [1:0] gid,
                               logic frdy, logic [3:0] ack);
      vec_t v;
      v.rdy  = rdy;
      v.fack = fack;
      v.vld  = vld;
      v.gid  = gid;
      v.frdy = frdy;
      v.ack  = ack;
      return v;
   endfunction

   function automatic logic [DW_M1:0] word_of(int k);
      return 9'h1A0 + 9'(k);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_data();
      for (int k = 0; k < NREQ; k++) bus.req_data[k*DW +: DW] = word_of(k);
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      bus.req_rdy = '0;
      bus.f_ack   = 1'b0;
      set_data();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Apply one cycle of inputs, check settled outputs, then advance past the edge.
   task automatic run_vec(input string tag, input vec_t v);
      bus.req_rdy = v.rdy;
      bus.f_ack   = v.fack;
      #1;
      chk({tag, ".grant_vld"}, 32'(bus.grant_vld), 32'(v.vld));
      chk({tag, ".f_rdy"}, 32'(bus.f_rdy), 32'(v.frdy));
      chk({tag, ".req_ack"}, 32'(bus.req_ack), 32'(v.ack));
      if (v.vld) begin
         chk({tag, ".grant_id"}, 32'(bus.grant_id), 32'(v.gid));
         chk({tag, ".f_data"}, 32'(bus.f_data), 32'(word_of(int'(v.gid))));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.req_rdy = '0;
      bus.f_ack   = 1'b0;
      set_data();
      #2;
      chk("rst.grant_vld", 32'(bus.grant_vld), 32'd0);
      chk("rst.grant_id", 32'(bus.grant_id), 32'd0);
      chk("rst.f_rdy", 32'(bus.f_rdy), 32'd0);
      chk("rst.req_ack", 32'(bus.req_ack), 32'd0);
      do_reset();

`ifndef RR_ARB_BURST_EN
      // All requesting: 0,1,2,3,0 with an idle cycle between grants.
      tbl.push_back(mk(4'b1111, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(4'b1111, 1, 1, 0, 1, 4'b0001));
      tbl.push_back(mk(4'b1111, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(4'b1111, 1, 1, 1, 1, 4'b0010));
      tbl.push_back(mk(4'b1111, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(4'b1111, 1, 1, 2, 1, 4'b0100));
      tbl.push_back(mk(4'b1111, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(4'b1111, 1, 1, 3, 1, 4'b1000));
      tbl.push_back(mk(4'b1111, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(4'b1111, 1, 1, 0, 1, 4'b0001));
      // Park last_id at 1, then 4'b1010 grants 3 then 1.
      tbl.push_back(mk(4'b0010, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(4'b0010, 1, 1, 1, 1, 4'b0010));
      tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(4'b1010, 1, 1, 3, 1, 4'b1000));
      tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(4'b1010, 1, 1, 1, 1, 4'b0010));
      tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 4'b0000));
      // FIFO full for 5 cycles holds grant 2; one beat then release.
      tbl.push_back(mk(4'b0100, 0, 0, 0, 0, 4'b0000));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b0100, 0, 1, 2, 1, 4'b0000));
      tbl.push_back(mk(4'b0100, 1, 1, 2, 1, 4'b0100));
      tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 4'b0000));
      // Requester drops without a beat: release sets last_id=0, so 1 beats 0 next.
      tbl.push_back(mk(4'b0001, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(4'b0000, 1, 1, 0, 0, 4'b0000));
      tbl.push_back(mk(4'b0011, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(4'b0011, 1, 1, 1, 1, 4'b0010));
      tbl.push_back(mk(4'b0000, 1, 0, 0, 0, 4'b0000));
      foreach (tbl[i]) run_vec($sformatf("v%0d", i), tbl[i]);
`else
      begin
         // Requester 1 alone with 6 words: 4 beats, idle, 2 beats, release on drop.
         logic exp_vld [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
         int   sent = 0;
         for (int c = 0; c < 10; c++) begin
            bus.req_rdy               = (sent < 6) ? 4'b0010 : 4'b0000;
            bus.req_data[1*DW +: DW]  = 9'h100 + 9'(sent);
            bus.f_ack                 = 1'b1;
            #1;
            chk($sformatf("b1.c%0d.grant_vld", c), 32'(bus.grant_vld), 32'(exp_vld[c]));
            if (bus.f_rdy && bus.f_ack) begin
               chk($sformatf("b1.beat%0d.f_data", sent), 32'(bus.f_data), 32'(9'h100 + 9'(sent)));
               chk($sformatf("b1.beat%0d.req_ack", sent), 32'(bus.req_ack), 32'd2);
               sent++;
            end
            @(posedge clk);
            #1;
         end
         chk("b1.beats", 32'(sent), 32'd6);
      end
      do_reset();
      // Requester 0 drops after 2 beats; 1 wins next even with 0 requesting again.
      run_vec("b2.c0", mk(4'b0011, 1, 0, 0, 0, 4'b0000));
      run_vec("b2.c1", mk(4'b0011, 1, 1, 0, 1, 4'b0001));
      run_vec("b2.c2", mk(4'b0011, 1, 1, 0, 1, 4'b0001));
      run_vec("b2.c3", mk(4'b0010, 1, 1, 0, 0, 4'b0000));
      run_vec("b2.c4", mk(4'b0011, 1, 0, 0, 0, 4'b0000));
      run_vec("b2.c5", mk(4'b0011, 1, 1, 1, 1, 4'b0010));
`endif

      // Reset mid-grant to 3, then requester 0 outranks pending 3.
      do_reset();
      bus.req_rdy = 4'b1000;
      bus.f_ack   = 1'b0;
      @(posedge clk);
      #1;
      chk("mr.grant_vld", 32'(bus.grant_vld), 32'd1);
      chk("mr.grant_id", 32'(bus.grant_id), 32'd3);
      chk("mr.f_rdy", 32'(bus.f_rdy), 32'd1);
      #2;
      bus.f_ack = 1'b1;
      rst_n     = 1'b0;
      #1;
      chk("mr.rst.grant_vld", 32'(bus.grant_vld), 32'd0);
      chk("mr.rst.f_rdy", 32'(bus.f_rdy), 32'd0);
      chk("mr.rst.req_ack", 32'(bus.req_ack), 32'd0);
      bus.req_rdy = 4'b1001;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mr.regrant.grant_vld", 32'(bus.grant_vld), 32'd1);
      chk("mr.regrant.grant_id", 32'(bus.grant_id), 32'd0);
      chk("mr.regrant.req_ack", 32'(bus.req_ack), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
